jx2_mem_arb_n: RTL and testbench
================================

Name: jx2_mem_arb_n

Overview:
- N-channel arbiter that multiplexes cache-tile refill and writeback requests (I$, D$, page-walker, DMA) onto one memory-tile port.
- Replaces the fixed two-way I$/D$ latch arbitration with a parametrised channel count, round-robin or fixed priority, a grant that holds until the transaction completes, a transaction timeout, and registered exception forwarding.
- Sits between the L1 tiles and the memory tile. The MMU stays on the upstream side of each channel.

Parameters:
- NCH, 2, number of requesting channels (2..8); channel 0 is the I$ port by convention.
- DW, 256, line data width (128 or 256).
- AW, 48, address width.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
- TMO_CYC, 4096, BUSY cycles before a timeout fault; 0 disables the timeout.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- chInAddr  in  NCH*AW  per-channel request address; channel i occupies slice [i*AW +: AW].
- chInData  in  NCH*DW  per-channel store data.
- chInOpm  in  NCH*5  per-channel opm; 0 = READY/idle.
- chOutData  out  DW  load data, broadcast to all channels.
- chOutOK  out  NCH*2  per-channel OK code.
- chGrant  out  NCH  one-hot current owner; all zero when no channel owns the port.
- memAddr  out  AW  address to the memory tile.
- memData  out  DW  store data to the memory tile.
- memOpm  out  5  opm to the memory tile.
- memInData  in  DW  load data from the memory tile.
- memOK  in  2  memory tile status.
- memExc  in  16  memory tile exception code.
- memTea  in  64  memory tile exception TEA.
- outExc  out  16  registered exception code.
- outTea  out  64  registered exception TEA.

Behaviour:
- OK encoding: 0 = READY, 1 = OK, 2 = HOLD, 3 = FAULT.
- Reset values: state IDLE, rrPtr = 0, grant = 0, tmoCnt = 0, outExc = 0, outTea = 0. memOpm = 0 and memAddr/memData = 0 while in IDLE.
- chOutData is wired straight to memInData at all times.
- State machine (3 states, registered):
  - IDLE:
    - Channel i gets OK = READY if its opm is 0, otherwise HOLD.
    - If any opm is nonzero and memOK == READY, pick a winner, latch it, and enter BUSY next cycle.
    - If memOK != READY, stay in IDLE.
  - BUSY:
    - memAddr, memData and memOpm follow the granted channel's inputs combinationally.
    - The granted channel sees OK = memOK. Every other channel sees HOLD if requesting, otherwise READY.
    - When the granted channel's opm reads 0, enter RELEASE.
  - RELEASE:
    - memOpm = 0; every channel is treated as in IDLE.
    - When memOK == READY, enter IDLE and set rrPtr = (grant index + 1) mod NCH.
- Latency: a request seen in cycle 0 (IDLE, memOK READY) drives memOpm in cycle 1. The minimum gap between back-to-back grants is 1 RELEASE cycle plus 1 IDLE cycle.
- Winner selection:
  - RR_MODE=1: first requester scanning rrPtr, rrPtr+1, ... with wrap modulo NCH.
  - RR_MODE=0: lowest-index requester; rrPtr is ignored.
- Requests that arrive simultaneously are resolved only by the selection rule; a loser keeps HOLD until it wins.
- The grant never changes mid-transaction, even if a higher-priority channel raises a request.
- Timeout:
  - tmoCnt clears on entry to BUSY and increments every BUSY cycle.
  - If TMO_CYC != 0 and tmoCnt reaches TMO_CYC - 1 while still BUSY, the granted channel gets OK = FAULT for exactly 1 cycle.
  - In that cycle outExc is loaded with 16'h8001 and outTea with {16'h0, granted address} the next cycle.
  - Then force RELEASE.
- A memOK = FAULT from the memory tile is passed through to the owner like any other OK code. The arbiter holds the grant until the owner drops its opm.
- Exceptions:
  - Every cycle, outExc/outTea <= memExc/memTea if memExc[15] is set, else 0.
  - A timeout overrides memExc in the same cycle.
- Reset asserted mid-BUSY: all outputs return to their reset values immediately (asynchronous), the grant drops, and the in-flight transaction is abandoned.

Test Plan:
1. NCH=2, RR: ch0 and ch1 both raise opm 5'h10 in the same cycle with memOK READY. Required: chGrant = 01, memAddr = ch0 address next cycle. After ch0 completes (OK then opm 0), ch1 is granted; chOutOK[1] = HOLD throughout ch0's transaction.
2. NCH=4, RR, all four channels requesting continuously. Required: grant order 0,1,2,3,0; no channel is granted twice before every other channel has been granted once.
3. NCH=4, RR_MODE=0, channels 1 and 3 requesting repeatedly. Required: channel 1 wins every arbitration; channel 3 is granted only when channel 1 is idle.
4. TMO_CYC=8, memOK held at HOLD. Required: chOutOK of the owner = 3 in BUSY cycle 8, then outExc = 16'h8001 and outTea = the owner's address; state returns to IDLE once memOK is READY.
5. memExc = 16'h8002 with memTea = 64'h1234 for 1 cycle. Required: outExc = 16'h8002 and outTea = 64'h1234 the following cycle, then 0.
6. Assert reset during BUSY. Required: memOpm = 0 and chGrant = 0 in the same cycle. After reset deasserts, the first grant goes to channel 0 (rrPtr = 0).

Source files
------------

// File: rtl/jx2_mem_arb_n.sv
// jx2_mem_arb_n -- N-channel memory-tile arbiter.
//
// Multiplexes NCH L1-side request channels (I$, D$, page walker, DMA, ...)
// onto a single memory-tile port. The arbiter grants one channel at a time and
// holds that grant until the owner drops its opm. Winners are chosen either
// round-robin (RR_MODE=1) or by fixed lowest-index priority (RR_MODE=0).
// If TMO_CYC is nonzero, a transaction that stays BUSY too long is faulted and
// released. Memory-tile exceptions are forwarded one cycle later through
// registers.
//
// Ports:
//   clock, reset         core clock, asynchronous active-high reset
//   chInAddr/Data/Opm    per-channel request; channel i at slice [i*W +: W]
//   chOutData            load data, broadcast (wired to memInData)
//   chOutOK              per-channel 2-bit OK code (0 READY,1 OK,2 HOLD,3 FAULT)
//   chGrant              one-hot owner, zero when nobody owns the port
//   memAddr/Data/Opm     request towards the memory tile
//   memInData/OK         response from the memory tile
//   memExc/memTea        memory tile exception code / TEA
//   outExc/outTea        registered exception code / TEA
module jx2_mem_arb_n #(
  parameter int NCH     = 2,
  parameter int DW      = 256,
  parameter int AW      = 48,
  parameter int RR_MODE = 1,
  parameter int TMO_CYC = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH*AW-1:0] chInAddr,
  input  logic [NCH*DW-1:0] chInData,
  input  logic [NCH*5-1:0]  chInOpm,
  output logic [DW-1:0]     chOutData,
  output logic [NCH*2-1:0]  chOutOK,
  output logic [NCH-1:0]    chGrant,
  output logic [AW-1:0]     memAddr,
  output logic [DW-1:0]     memData,
  output logic [4:0]        memOpm,
  input  logic [DW-1:0]     memInData,
  input  logic [1:0]        memOK,
  input  logic [15:0]       memExc,
  input  logic [63:0]       memTea,
  output logic [15:0]       outExc,
  output logic [63:0]       outTea
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  localparam logic [1:0] OK_READY = 2'd0;
  localparam logic [1:0] OK_HOLD  = 2'd2;
  localparam logic [1:0] OK_FAULT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [15:0]     out_exc_q, out_exc_d;
  logic [63:0]     out_tea_q, out_tea_d;

  logic [AW-1:0]   ch_addr [NCH];
  logic [DW-1:0]   ch_data [NCH];
  logic [4:0]      ch_opm  [NCH];
  logic [NCH-1:0]  ch_req;

  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand_idx;
  logic            win_found;
  logic            busy;
  logic            tmo_fire;

  // Unpack the flat per-channel buses.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      ch_addr[i] = chInAddr[i*AW +: AW];
      ch_data[i] = chInData[i*DW +: DW];
      ch_opm[i]  = chInOpm[i*5 +: 5];
      ch_req[i]  = |chInOpm[i*5 +: 5];
    end
  end

  // Winner: first requester scanning from rr_ptr (round-robin) or from 0.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (RR_MODE != 0) cand_idx = IW'((32'(rr_ptr_q) + k) % NCH);
      else              cand_idx = IW'(k);
      if (!win_found && ch_req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign busy     = (state_q == ST_BUSY);
  assign tmo_fire = (TMO_CYC != 0) && busy && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found && memOK == OK_READY) begin
          state_d   = ST_BUSY;
          gnt_idx_d = win_idx;
          tmo_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (ch_opm[gnt_idx_q] == 5'd0 || tmo_fire) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (memOK == OK_READY) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (gnt_idx_q == IW'(NCH - 1)) ? '0 : gnt_idx_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A timeout takes precedence over whatever the memory tile reports.
  always_comb begin
    out_exc_d = '0;
    out_tea_d = '0;
    if (tmo_fire) begin
      out_exc_d = 16'h8001;
      out_tea_d = 64'(ch_addr[gnt_idx_q]);
    end else if (memExc[15]) begin
      out_exc_d = memExc;
      out_tea_d = memTea;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
      tmo_cnt_q <= '0;
      out_exc_q <= '0;
      out_tea_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      out_exc_q <= out_exc_d;
      out_tea_q <= out_tea_d;
    end
  end

  // Only the BUSY owner sees the memory status; everyone else sees the
  // idle view (HOLD while requesting, READY otherwise).
  always_comb begin
    chOutOK = '0;
    chGrant = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      chOutOK[i*2 +: 2] = ch_req[i] ? OK_HOLD : OK_READY;
      if (busy && gnt_idx_q == IW'(i)) begin
        chOutOK[i*2 +: 2] = tmo_fire ? OK_FAULT : memOK;
        chGrant[i]        = 1'b1;
      end
    end
  end

  assign memAddr   = busy ? ch_addr[gnt_idx_q] : '0;
  assign memData   = busy ? ch_data[gnt_idx_q] : '0;
  assign memOpm    = busy ? ch_opm[gnt_idx_q]  : '0;
  assign chOutData = memInData;
  assign outExc    = out_exc_q;
  assign outTea    = out_tea_q;

endmodule

// File: tb/tb_jx2_mem_arb_n.sv
module tb_jx2_mem_arb_n;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [47:0]  A0 = 48'h0000_1234_5A00;
  localparam logic [47:0]  A1 = 48'h0000_CAFE_0B40;
  localparam logic [255:0] D0 = 256'h0D00_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_00D0;
  localparam logic [255:0] D1 = 256'h0D11_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_00D1;

  // DUT A: NCH=2, round-robin, short timeout
  logic [95:0]  a_addr;
  logic [511:0] a_data;
  logic [9:0]   a_opm;
  logic [255:0] a_out_data;
  logic [3:0]   a_ok;
  logic [1:0]   a_grant;
  logic [47:0]  a_maddr;
  logic [255:0] a_mdata;
  logic [4:0]   a_mopm;
  logic [255:0] a_min;
  logic [1:0]   a_mok;
  logic [15:0]  a_mexc;
  logic [63:0]  a_mtea;
  logic [15:0]  a_oexc;
  logic [63:0]  a_otea;

  // DUTs B (round-robin) and C (fixed priority): NCH=4, shared memory side
  logic [127:0] bc_addr;
  logic [511:0] bc_data;
  logic [127:0] bc_min;
  logic [1:0]   bc_mok;
  logic [15:0]  bc_mexc;
  logic [63:0]  bc_mtea;
  logic [19:0]  b_opm, c_opm;
  logic [127:0] b_out_data, c_out_data;
  logic [7:0]   b_ok, c_ok;
  logic [3:0]   b_grant, c_grant;
  logic [31:0]  b_maddr, c_maddr;
  logic [127:0] b_mdata, c_mdata;
  logic [4:0]   b_mopm, c_mopm;
  logic [15:0]  b_oexc, c_oexc;
  logic [63:0]  b_otea, c_otea;

  jx2_mem_arb_n #(.NCH(2), .DW(256), .AW(48), .RR_MODE(1), .TMO_CYC(8)) u_a (
    .clock(clock), .reset(reset),
    .chInAddr(a_addr), .chInData(a_data), .chInOpm(a_opm),
    .chOutData(a_out_data), .chOutOK(a_ok), .chGrant(a_grant),
    .memAddr(a_maddr), .memData(a_mdata), .memOpm(a_mopm),
    .memInData(a_min), .memOK(a_mok), .memExc(a_mexc), .memTea(a_mtea),
    .outExc(a_oexc), .outTea(a_otea)
  );

  jx2_mem_arb_n #(.NCH(4), .DW(128), .AW(32), .RR_MODE(1), .TMO_CYC(0)) u_b (
    .clock(clock), .reset(reset),
    .chInAddr(bc_addr), .chInData(bc_data), .chInOpm(b_opm),
    .chOutData(b_out_data), .chOutOK(b_ok), .chGrant(b_grant),
    .memAddr(b_maddr), .memData(b_mdata), .memOpm(b_mopm),
    .memInData(bc_min), .memOK(bc_mok), .memExc(bc_mexc), .memTea(bc_mtea),
    .outExc(b_oexc), .outTea(b_otea)
  );

  jx2_mem_arb_n #(.NCH(4), .DW(128), .AW(32), .RR_MODE(0), .TMO_CYC(0)) u_c (
    .clock(clock), .reset(reset),
    .chInAddr(bc_addr), .chInData(bc_data), .chInOpm(c_opm),
    .chOutData(c_out_data), .chOutOK(c_ok), .chGrant(c_grant),
    .memAddr(c_maddr), .memData(c_mdata), .memOpm(c_mopm),
    .memInData(bc_min), .memOK(bc_mok), .memExc(bc_mexc), .memTea(bc_mtea),
    .outExc(c_oexc), .outTea(c_otea)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_addr = {A1, A0};
    a_data = {D1, D0};
    a_opm  = '0;
    a_min  = 256'hFEED_0001;
    a_mok  = 2'd0;
    a_mexc = '0;
    a_mtea = '0;
    bc_addr = {32'h3333_0300, 32'h2222_0200, 32'h1111_0100, 32'h0A0A_0000};
    bc_data = {128'h33, 128'h22, 128'h11, 128'h0A};
    bc_min  = 128'h5A5A;
    bc_mok  = 2'd0;
    bc_mexc = '0;
    bc_mtea = '0;
    b_opm   = '0;
    c_opm   = '0;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_grant", a_grant, 2'b00);
    chk("rst_opm",   a_mopm,  5'h00);
    chk("rst_addr",  a_maddr, 48'h0);
    chk("rst_exc",   a_oexc,  16'h0);
    chk("rst_tea",   a_otea,  64'h0);
    chk("rst_ok",    a_ok,    4'b0000);

    // ---- simultaneous requests, round-robin, NCH=2
    a_opm = {5'h10, 5'h10};
    #1;
    chk("t1_idle_ok",    a_ok,       4'b1010);
    chk("t1_idle_grant", a_grant,    2'b00);
    chk("t1_idle_opm",   a_mopm,     5'h00);
    chk("t1_outdata",    a_out_data, 256'hFEED_0001);
    tick;
    chk("t1_b1_grant", a_grant, 2'b01);
    chk("t1_b1_addr",  a_maddr, A0);
    chk("t1_b1_data",  a_mdata, D0);
    chk("t1_b1_opm",   a_mopm,  5'h10);
    chk("t1_b1_ok",    a_ok,    4'b1000);
    a_mok = 2'd2;
    #1;
    chk("t1_b1_okhold", a_ok, 4'b1010);
    tick;
    a_mok = 2'd1;
    #1;
    chk("t1_b2_ok",    a_ok,    4'b1001);
    chk("t1_b2_grant", a_grant, 2'b01);
    tick;
    a_opm[4:0] = 5'h00;
    a_mok = 2'd0;
    #1;
    chk("t1_b3_opm",   a_mopm,  5'h00);
    chk("t1_b3_grant", a_grant, 2'b01);
    tick;
    chk("t1_rel_grant", a_grant, 2'b00);
    chk("t1_rel_ok",    a_ok,    4'b1000);
    chk("t1_rel_addr",  a_maddr, 48'h0);
    tick;
    chk("t1_idle2_grant", a_grant, 2'b00);
    chk("t1_idle2_ok",    a_ok,    4'b1000);
    tick;
    chk("t1_ch1_grant", a_grant, 2'b10);
    chk("t1_ch1_addr",  a_maddr, A1);
    chk("t1_ch1_ok",    a_ok,    4'b0000);
    a_opm[9:5] = 5'h00;
    tick;
    tick;

    // ---- exception forwarding
    a_mexc = 16'h8002;
    a_mtea = 64'h1234;
    tick;
    a_mexc = 16'h0002;
    a_mtea = 64'h5555;
    #1;
    chk("t5_exc", a_oexc, 16'h8002);
    chk("t5_tea", a_otea, 64'h1234);
    tick;
    a_mexc = '0;
    a_mtea = '0;
    #1;
    chk("t5_exc_clr", a_oexc, 16'h0);
    chk("t5_tea_clr", a_otea, 64'h0);

    // ---- timeout (TMO_CYC=8), memOK stuck at HOLD
    a_opm = {5'h00, 5'h11};
    tick;
    a_mok = 2'd2;
    #1;
    for (int c = 1; c < 8; c++) begin
      chk($sformatf("t4_hold_c%0d", c), a_ok[1:0], 2'd2);
      tick;
    end
    a_mexc = 16'h8003;
    a_mtea = 64'hDEAD;
    #1;
    chk("t4_fault_ok",    a_ok[1:0], 2'd3);
    chk("t4_fault_grant", a_grant,   2'b01);
    chk("t4_fault_exc0",  a_oexc,    16'h0);
    tick;
    a_mexc = '0;
    a_mtea = '0;
    #1;
    chk("t4_exc",       a_oexc,    16'h8001);
    chk("t4_tea",       a_otea,    {16'h0, A0});
    chk("t4_rel_opm",   a_mopm,    5'h00);
    chk("t4_rel_grant", a_grant,   2'b00);
    chk("t4_rel_ok",    a_ok[1:0], 2'd2);
    tick;
    chk("t4_exc_clr",    a_oexc,  16'h0);
    chk("t4_rel2_grant", a_grant, 2'b00);
    a_mok = 2'd0;
    a_opm = {5'h10, 5'h11};
    tick;
    tick;
    chk("t4_next_grant", a_grant, 2'b10);
    chk("t4_next_ok",    a_ok,    4'b0010);
    a_opm = '0;
    tick;
    tick;

    // ---- reset in the middle of a transaction
    a_opm = {5'h10, 5'h00};
    tick;
    chk("t6_busy_grant", a_grant, 2'b10);
    chk("t6_busy_opm",   a_mopm,  5'h10);
    reset = 1'b1;
    #1;
    chk("t6_rst_opm",   a_mopm,  5'h00);
    chk("t6_rst_grant", a_grant, 2'b00);
    chk("t6_rst_addr",  a_maddr, 48'h0);
    chk("t6_rst_ok",    a_ok,    4'b1000);
    a_opm = {5'h10, 5'h10};
    tick;
    reset = 1'b0;
    tick;
    chk("t6_first_grant", a_grant, 2'b01);
    a_opm = '0;
    tick;
    tick;

    // ---- NCH=4 round-robin, every channel requesting
    b_opm = {4{5'h10}};
    for (int g = 0; g < 5; g++) begin
      int own;
      logic [7:0] exp_ok;
      own = g % 4;
      exp_ok = 8'b1010_1010;
      exp_ok[own*2 +: 2] = 2'b00;
      tick;
      chk($sformatf("t2_grant_%0d", g), b_grant, 4'b0001 << own);
      chk($sformatf("t2_ok_%0d", g),    b_ok,    exp_ok);
      chk($sformatf("t2_addr_%0d", g),  b_maddr, bc_addr[own*32 +: 32]);
      b_opm[own*5 +: 5] = 5'h00;
      tick;
      b_opm[own*5 +: 5] = 5'h10;
      tick;
    end
    b_opm = '0;
    tick;

    // ---- NCH=4 fixed priority, channels 1 and 3
    c_opm = {5'h10, 5'h00, 5'h10, 5'h00};
    for (int r = 0; r < 3; r++) begin
      tick;
      chk($sformatf("t3_grant_%0d", r), c_grant, 4'b0010);
      chk($sformatf("t3_ok_%0d", r),    c_ok,    8'b1000_0000);
      c_opm[9:5] = 5'h00;
      tick;
      c_opm[9:5] = 5'h10;
      tick;
    end
    c_opm[9:5] = 5'h00;
    tick;
    chk("t3_ch3_grant", c_grant, 4'b1000);
    chk("t3_ch3_addr",  c_maddr, 32'h3333_0300);
    c_opm[9:5] = 5'h10;
    #1;
    chk("t3_ch3_ok", c_ok, 8'b0000_1000);
    tick;
    chk("t3_hold_grant", c_grant, 4'b1000);
    c_opm[19:15] = 5'h00;
    tick;
    tick;
    tick;
    chk("t3_ch1_again", c_grant, 4'b0010);
    c_opm = '0;
    tick;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
